// File: rtl/ps2_key_event_decoder.sv
// PS/2 keyboard receiver: conditions the raw link, deframes 11-bit frames and
// turns scan-code set 2 bytes into {press, keycode} key events.
// Ports: w_Clk, w_Reset (async, active-high), w_Ps2Clk/w_Ps2Data (raw lines),
//        o_KeyEvent (held event byte), o_KeyValid / o_FrameError (strobes).
module ps2_key_event_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       w_Clk,
  input  logic       w_Reset,
  input  logic       w_Ps2Clk,
  input  logic       w_Ps2Data,
  output logic [7:0] o_KeyEvent,
  output logic       o_KeyValid,
  output logic       o_FrameError
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK,
    SKIP
  } state_t;

  // synchronizers; idle-high so reset never fakes an edge
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge w_Clk or posedge w_Reset) begin
    if (w_Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= w_Ps2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= w_Ps2Data;
      dat_s2 <= dat_s1;
    end
  end

  // clock filter: level flips after FILTER_LEN differing samples in a row
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          stb;

  always_ff @(posedge w_Clk or posedge w_Reset) begin
    if (w_Reset) begin
      filt <= 1'b1;
      fcnt <= '0;
      stb  <= 1'b0;
    end else begin
      stb <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        fcnt <= '0;
        filt <= clk_s2;
        stb  <= ~clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // deframer + timeout; s1_* is the registered frame check
  logic [3:0]    bitcnt;
  logic [9:0]    sh;
  logic [TW-1:0] tcnt;
  logic          s1_vld, s1_err;
  logic [7:0]    s1_byte;
  logic          ok;

  // sh[0]=start, sh[8:1]=data, sh[9]=parity; stop is the current sample
  assign ok = ~sh[0] & dat_s2 & (^sh[9:1]);

  always_ff @(posedge w_Clk or posedge w_Reset) begin
    if (w_Reset) begin
      bitcnt  <= '0;
      sh      <= '0;
      tcnt    <= '0;
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_byte <= '0;
    end else begin
      s1_vld <= 1'b0;
      s1_err <= 1'b0;
      if (stb) begin
        tcnt <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt  <= '0;
          s1_vld  <= ok;
          s1_err  <= ~ok;
          s1_byte <= sh[8:1];
        end else begin
          sh     <= {dat_s2, sh[9:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        if (tcnt == T_LAST) begin
          tcnt   <= '0;
          bitcnt <= '0;
          s1_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // shift keys swap places so left/right shift land on 0x70/0x71
  function automatic logic [6:0] map_key(input logic [7:0] b);
    case (b)
      8'h12:   map_key = 7'h70;
      8'h59:   map_key = 7'h71;
      8'h70:   map_key = 7'h12;
      8'h71:   map_key = 7'h59;
      default: map_key = b[6:0];
    endcase
  endfunction

  state_t     state, state_n;
  logic [2:0] skip, skip_n;
  logic       emit;
  logic [7:0] ev;
  logic       is_key;

  assign is_key = ~s1_byte[7] & (s1_byte != 8'h00);

  always_ff @(posedge w_Clk or posedge w_Reset) begin
    if (w_Reset) begin
      state        <= IDLE;
      skip         <= '0;
      o_KeyEvent   <= 8'h00;
      o_KeyValid   <= 1'b0;
      o_FrameError <= 1'b0;
    end else begin
      state        <= state_n;
      skip         <= skip_n;
      o_KeyValid   <= emit;
      o_FrameError <= s1_err;
      if (emit) o_KeyEvent <= ev;
    end
  end

  always_comb begin
    state_n = state;
    skip_n  = skip;
    emit    = 1'b0;
    ev      = 8'h00;
    if (s1_err) begin
      state_n = IDLE;
      skip_n  = '0;
    end else if (s1_vld) begin
      case (state)
        IDLE: begin
          unique case (1'b1)
            s1_byte == 8'hF0: state_n = BREAK;
            s1_byte == 8'hE0: state_n = EXT;
            s1_byte == 8'hE1: begin
              state_n = SKIP;
              skip_n  = 3'd7;
            end
            is_key: begin
              emit = 1'b1;
              ev   = {1'b1, map_key(s1_byte)};
            end
            default: state_n = IDLE;
          endcase
        end
        BREAK: begin
          state_n = IDLE;
          if (is_key) begin
            emit = 1'b1;
            ev   = {1'b0, map_key(s1_byte)};
          end
        end
        EXT: begin
          state_n = (s1_byte == 8'hF0) ? EXT_BREAK : IDLE;
        end
        EXT_BREAK: state_n = IDLE;
        SKIP: begin
          skip_n = skip - 3'd1;
          if (skip == 3'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
